serial_unsigned_cmp: RTL
========================

Name: serial_unsigned_cmp

Overview:
- Multi-cycle, digit-serial unsigned magnitude comparator. Scans two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and stops early at the first differing digit.
- Sequential counterpart of the flat combinational 32-bit less-than comparator. It trades latency for a single DIGIT-wide compare slice.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.
- Produces one-hot lt/eq/gt, where lt means a < b.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- lt  output  1  a < b.
- eq  output  1  a == b.
- gt  output  1  a > b.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State goes to IDLE.
  - in_ready=1; out_valid=0; lt=eq=gt=0; busy=0.
  - Internal shift registers and digit counter cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: capture a and b into shift registers sa and sb, load cnt=WIDTH/DIGIT, go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle compares da=sa[WIDTH-1 -: DIGIT] against db=sb[WIDTH-1 -: DIGIT], both unsigned.
  - If da<db: lt<=1, go DONE.
  - If da>db: gt<=1, go DONE.
  - If da==db: shift sa and sb left by DIGIT (zero-fill) and decrement cnt.
    - If cnt reaches 0 on this step, eq<=1 and go DONE.
    - Otherwise stay in SCAN.
- DONE:
  - out_valid=1; exactly one of lt/eq/gt is 1.
  - Result is held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: clear lt/eq/gt and out_valid, go IDLE.
- Latency:
  - Let k be the 1-based index, MSB-first, of the first differing digit; k=WIDTH/DIGIT if the operands are equal.
  - out_valid rises k edges after the accept edge.
  - Minimum latency is 1; maximum is WIDTH/DIGIT (8 for the defaults).
- Throughput:
  - There is no overlap: a new accept happens no earlier than the edge after the result handshake.
  - Best-case issue interval is k+2 cycles.
- Outputs are registered; no combinational path from in_valid or out_ready to any output.
- in_valid is ignored outside IDLE; a and b may change freely while not accepted.
- Boundaries:
  - a=b=0 returns eq after WIDTH/DIGIT cycles.
  - All-ones operands behave the same way.
  - DIGIT=WIDTH gives single-cycle latency.
- A reset asserted mid-SCAN or in DONE aborts immediately. No out_valid pulse is produced, and the pending result is discarded.
- out_ready asserted outside DONE has no effect.
- Invariant: lt+eq+gt<=1 at all times, and ==1 exactly when out_valid=1.

Test Plan:
- Defaults; a=0x00000001, b=0x80000000 -> out_valid 1 cycle after accept, lt=1, eq=gt=0.
- a=0x12345678, b=0x12345677 -> gt=1, out_valid 8 cycles after accept. Also a=0x12345670, b=0x12345680 -> lt=1 at cycle 7.
- a=b=0xDEADBEEF -> eq=1 after 8 cycles. Also a=b=0 -> eq=1 after 8 cycles.
- Backpressure: a=5, b=9, out_ready held 0 for 5 cycles after out_valid.
  - Required: lt=1 stable throughout, in_ready=0.
  - Drive a new pair with in_valid=1 during the hold: it is ignored.
  - Accept occurs the cycle after the out_ready handshake.
- Reset mid-SCAN: a=b=0xFFFFFFFF, pulse rst_n low at cycle 3 of SCAN.
  - Required: outputs go to reset values immediately, no out_valid appears, then in_ready=1.
  - A follow-up compare of a=2, b=1 returns gt=1.
- Randomized 10k pairs at DIGIT=1, 4 and 32 against a reference a<b / a==b model.
  - Required: one-hot result matches the model.
  - Latency equals the first-differing-digit index.

Source files
------------

// File: rtl/serial_unsigned_cmp.sv
// Digit-serial unsigned magnitude comparator.
// Scans two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and stops
// at the first differing digit. Produces a one-hot lt/eq/gt result behind
// valid/ready handshakes on both the operand side and the result side.
module serial_unsigned_cmp #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             busy
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lt_q, lt_d;
  logic              eq_q, eq_d;
  logic              gt_q, gt_d;

  logic [DIGIT-1:0]  da;
  logic [DIGIT-1:0]  db;

  // Current top digits of the two shift registers.
  always_comb begin
    da = sa_q[WIDTH-1 -: DIGIT];
    db = sb_q[WIDTH-1 -: DIGIT];
  end

  // Next-state, datapath and result logic.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(NDIG);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (da < db) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (da > db) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << DIGIT;
          sb_d  = sb_q << DIGIT;
          cnt_d = cnt_q - 1'b1;
          // Last digit matched: the whole operands are equal.
          if (cnt_q == CW'(1)) begin
            eq_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  // Handshake and status outputs decode only the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    lt        = lt_q;
    eq        = eq_q;
    gt        = gt_q;
  end

endmodule
